// File: rtl/pesanteur_n_colonnes.sv
// Gravity engine for the falling-brick game.
// Owns per-column stack heights, drops one brick at a time, clears full bottom lines.
module pesanteur_n_colonnes #(
  parameter  int N_COLS = 3,
  parameter  int N_ROWS = 6,
  localparam int COL_W  = ($clog2(N_COLS) > 1) ? $clog2(N_COLS) : 1,
  localparam int ROW_W  = ($clog2(N_ROWS) > 1) ? $clog2(N_ROWS) : 1,
  localparam int HGT_W  = $clog2(N_ROWS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    tick,
  input  logic                    spawn_valid,
  input  logic [COL_W-1:0]        spawn_col,
  output logic                    spawn_ready,
  input  logic                    move_left,
  input  logic                    move_right,
  output logic [ROW_W-1:0]        row,
  output logic [COL_W-1:0]        col,
  output logic                    falling,
  output logic [N_COLS*HGT_W-1:0] heights,
  output logic                    landed,
  output logic                    cleared,
  output logic                    game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FALL,
    S_LAND,
    S_CLEAR,
    S_OVER
  } state_t;

  state_t           state;
  logic [HGT_W-1:0] hgt [N_COLS];

  logic             at_rest;
  logic             all_nz;
  logic             shift_ok;
  logic [COL_W-1:0] dst;
  logic [COL_W-1:0] spawn_cl;

  always_comb begin
    at_rest = (int'(row) + int'(hgt[col])) == (N_ROWS - 1);
    all_nz  = 1'b1;
    for (int c = 0; c < N_COLS; c++) begin
      if (hgt[c] == '0) all_nz = 1'b0;
    end
    if (int'(spawn_col) > N_COLS - 1) begin
      spawn_cl = COL_W'(N_COLS - 1);
    end else begin
      spawn_cl = spawn_col;
    end
  end

  // Shift target must exist and its stack top must lie below the brick.
  always_comb begin
    dst      = col;
    shift_ok = 1'b0;
    if (move_left && !move_right && col != '0) begin
      dst      = col - COL_W'(1);
      shift_ok = 1'b1;
    end else if (move_right && !move_left &&
                 int'(col) < N_COLS - 1) begin
      dst      = col + COL_W'(1);
      shift_ok = 1'b1;
    end
    if (shift_ok &&
        int'(row) >= N_ROWS - int'(hgt[dst])) begin
      shift_ok = 1'b0;
    end
  end

  always_comb begin
    heights = '0;
    for (int c = 0; c < N_COLS; c++) begin
      heights[c*HGT_W +: HGT_W] = hgt[c];
    end
  end

  assign spawn_ready = (state == S_IDLE);
  assign falling     = (state == S_FALL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      landed    <= 1'b0;
      cleared   <= 1'b0;
      game_over <= 1'b0;
      for (int c = 0; c < N_COLS; c++) hgt[c] <= '0;
    end else if (start) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      landed    <= 1'b0;
      cleared   <= 1'b0;
      game_over <= 1'b0;
      for (int c = 0; c < N_COLS; c++) hgt[c] <= '0;
    end else begin
      landed  <= 1'b0;
      cleared <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (spawn_valid) begin
            col   <= spawn_cl;
            row   <= '0;
            state <= S_FALL;
          end
        end
        S_FALL: begin
          if (tick) begin
            if (at_rest) begin
              hgt[col] <= hgt[col] + HGT_W'(1);
              landed   <= 1'b1;
              state    <= S_LAND;
            end else begin
              row <= row + ROW_W'(1);
            end
          end else if (shift_ok) begin
            col <= dst;
          end
        end
        S_LAND: begin
          if (all_nz) begin
            for (int c = 0; c < N_COLS; c++) begin
              hgt[c] <= hgt[c] - HGT_W'(1);
            end
            cleared <= 1'b1;
            state   <= S_CLEAR;
          end else if (hgt[col] == HGT_W'(N_ROWS)) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
